// File: rtl/act_drain_l1_if.sv
// rtl/act_drain_l1_if.sv - activation output stream (valid/ready beat with index)
interface act_drain_l1_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/act_drain_l1.sv
// rtl/act_drain_l1.sv - captures 32 accumulators, streams shifted+saturated int8 activations
// Optional ReLU clamp selected by macro ACT_DRAIN_RELU_EN (default: signed saturation only).
module act_drain_l1 #(
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [639:0]         acc_in_packed,
  output logic                 busy,
  output logic                 done,
  act_drain_l1_if.master       out_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic signed [19:0] acc_q [32];
  logic signed [19:0] acc_d [32];
  logic               capture;

  // Floor shift (arithmetic >>>) followed by the build-selected clamp.
  function automatic logic signed [7:0] act_of(input logic signed [19:0] acc);
    logic signed [19:0] q;
    logic signed [7:0]  r;
    q = acc >>> SHIFT;
`ifdef ACT_DRAIN_RELU_EN
    if (q < 20'sd0)
      r = 8'sd0;
    else if (q > 20'sd127)
      r = 8'sd127;
    else
      r = q[7:0];
`else
    if (q < -20'sd128)
      r = -8'sd128;
    else if (q > 20'sd127)
      r = 8'sd127;
    else
      r = q[7:0];
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) capture = 1'b1;
      end
      STREAM: begin
        if (out_if.out_ready) begin
          if (idx_q == 5'd31) begin
            state_d = FIN;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (start) capture = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A start in IDLE or FIN snapshots the whole vector; STREAM never recaptures.
    if (capture) begin
      state_d = STREAM;
      idx_d   = 5'd0;
      for (int j = 0; j < 32; j++) begin
        acc_d[j] = acc_in_packed[j*20 +: 20];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      for (int j = 0; j < 32; j++) begin
        acc_q[j] <= 20'sd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    busy             = (state_q == STREAM);
    done             = (state_q == FIN);
    out_if.out_valid = busy;
    out_if.out_idx   = idx_q;
    out_if.out_data  = busy ? act_of(acc_q[idx_q]) : 8'sd0;
  end

endmodule

// File: tb/tb_act_drain_l1.sv
// tb/tb_act_drain_l1.sv - randomized bench for act_drain_l1 against a beat-level reference model
module tb_act_drain_l1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [639:0] acc_in_packed;
  logic         busy;
  logic         done;

  act_drain_l1_if dif ();

  act_drain_l1 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .acc_in_packed (acc_in_packed),
    .busy          (busy),
    .done          (done),
    .out_if        (dif.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_valid;
  bit exp_done;
  bit exp_clear;
  bit directed;
  int exp_idx;
  int exp_vals [32];
  int directed_tbl [4];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int acc_at(input logic [639:0] a, input int j);
    logic signed [19:0] t;
    t = a[j*20 +: 20];
    return int'(t);
  endfunction

  // floor(acc / 256), then clamp to the build's output range
  function automatic int ref_act(input int acc);
    int q;
    if (acc >= 0) q = acc / 256;
    else          q = -((-acc + 255) / 256);
`ifdef ACT_DRAIN_RELU_EN
    if (q < 0) q = 0;
`else
    if (q < -128) q = -128;
`endif
    if (q > 127) q = 127;
    return q;
  endfunction

  function automatic logic [639:0] rand_pack();
    logic [639:0] v;
    int           x;
    v = '0;
    for (int j = 0; j < 32; j++) begin
      if ($urandom % 3 == 0) x = int'($urandom % 1048576) - 524288;
      else                   x = int'($urandom_range(0, 65535)) - 32768;
      v[j*20 +: 20] = 20'(x);
    end
    return v;
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'd0, dif.out_valid}, {31'd0, exp_valid});
    check("busy", {31'd0, busy}, {31'd0, exp_valid});
    check("done", {31'd0, done}, {31'd0, exp_done});
    if (exp_valid) begin
      check("out_idx", {27'd0, dif.out_idx}, exp_idx);
      check("out_data", 32'($signed(dif.out_data)), exp_vals[exp_idx]);
      if (directed && exp_idx < 4)
        check("scenario_data", 32'($signed(dif.out_data)), directed_tbl[exp_idx]);
    end
    if (exp_clear) begin
      check("rst_idx", {27'd0, dif.out_idx}, 0);
      check("rst_data", {24'd0, dif.out_data}, 0);
    end
  endtask

  // One clock: check what the DUT shows now, then apply inputs for the next edge.
  task automatic step(input bit r, input bit s, input bit rd, input logic [639:0] a);
    @(negedge clk);
    check_outputs();
    rst           = r;
    start         = s;
    dif.out_ready = rd;
    acc_in_packed = a;
    if (r) begin
      exp_valid = 0; exp_done = 0; exp_idx = 0; exp_clear = 1; directed = 0;
    end else if (!exp_valid && s) begin
      for (int j = 0; j < 32; j++) exp_vals[j] = ref_act(acc_at(a, j));
      exp_valid = 1; exp_idx = 0; exp_done = 0; exp_clear = 0;
    end else if (exp_valid && rd) begin
      if (exp_idx == 31) begin
        exp_valid = 0; exp_done = 1; exp_idx = 0; directed = 0;
      end else begin
        exp_idx++;
        exp_done = 0;
      end
    end else begin
      exp_done = 0;
    end
  endtask

  initial begin
    logic [639:0] dir_pack;
    bit           rd;

    rst = 1'b1; start = 1'b0; dif.out_ready = 1'b0; acc_in_packed = '0;
    exp_valid = 0; exp_done = 0; exp_clear = 1; exp_idx = 0; directed = 0;
`ifdef ACT_DRAIN_RELU_EN
    directed_tbl[0] = 1; directed_tbl[1] = 0;  directed_tbl[2] = 127; directed_tbl[3] = 0;
`else
    directed_tbl[0] = 1; directed_tbl[1] = -1; directed_tbl[2] = 127; directed_tbl[3] = -2;
`endif
    dir_pack = '0;
    dir_pack[0*20 +: 20] = 20'(256);
    dir_pack[1*20 +: 20] = 20'(-256);
    dir_pack[2*20 +: 20] = 20'(40000);
    dir_pack[3*20 +: 20] = 20'(-300);

    repeat (3) step(1, 0, 0, '0);

    // Start right after reset with the fixed scenario, inputs scrambled afterwards.
    directed = 1;
    step(0, 1, 1, dir_pack);
    repeat (32) step(0, 0, 1, rand_pack());

    // Start in the done cycle, then a start and new data at beat 10, then reset at beat 15.
    step(0, 1, 1, rand_pack());
    repeat (10) step(0, 0, 1, rand_pack());
    step(0, 1, 1, rand_pack());
    repeat (4) step(0, 0, 1, rand_pack());
    step(1, 0, 1, rand_pack());
    repeat (3) step(0, 0, 1, rand_pack());

    // Backpressure pattern 1,0,0,1.
    step(0, 1, 0, rand_pack());
    for (int k = 0; k < 140; k++) begin
      rd = (k % 4 == 0) || (k % 4 == 3);
      step(0, 0, rd, rand_pack());
    end

    // Random traffic with sporadic starts and resets.
    for (int k = 0; k < 3000; k++) begin
      rd = ($urandom % 4 != 0);
      step(($urandom % 300) == 0, ($urandom % 6) == 0, rd, rand_pack());
    end
    repeat (40) step(0, 0, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/act_drain_l1.md
ACT_DRAIN_L1 -- requirements
Module: act_drain_l1

Interface
REQ-001: Parameter SHIFT, default 8, SHALL be the arithmetic right-shift applied to each accumulator (removes the x256 bias/product scaling).
REQ-002: clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003: rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004: start  input  1  SHALL request capture of acc_in_packed; it is honoured only when busy=0.
REQ-005: acc_in_packed  input  640  SHALL carry 32 signed 20-bit accumulators; neuron j occupies bits [j*20 +: 20].
REQ-006: busy  output  1  SHALL be high from the capture cycle until the last beat is accepted.
REQ-007: out_valid  output  1  SHALL indicate that out_data/out_idx hold a valid activation.
REQ-008: out_ready  input  1  SHALL be the downstream acceptance; a beat transfers when out_valid and out_ready are both high on a clk edge.
REQ-009: out_data  output  8  SHALL be the signed int8 activation for neuron out_idx.
REQ-010: out_idx  output  5  SHALL be the neuron index 0..31 of the current beat.
REQ-011: done  output  1  SHALL pulse high for one cycle after beat 31 transfers.

Function
REQ-012: The FSM SHALL have exactly three states: IDLE, STREAM and FIN.
- IDLE -> STREAM on start.
- STREAM -> FIN on transfer of beat 31.
- FIN -> IDLE unconditionally, or FIN -> STREAM if start is asserted in FIN.
REQ-013: On an accepted start, the block SHALL register all 32 accumulators in that same edge; later changes on acc_in_packed SHALL NOT affect the stream.
REQ-014: Latency SHALL be one cycle: out_valid=1 with out_idx=0 in the cycle after the start edge.
REQ-015: While out_valid=1 and out_ready=0, out_data and out_idx SHALL stay stable and out_valid SHALL stay high.
REQ-016: Each transfer SHALL advance out_idx by 1, with no bubble cycles under continuous out_ready=1: 32 beats in 32 cycles.
REQ-017: Arithmetic SHALL compute q = acc >>> SHIFT (sign-preserving, floor toward -inf), then saturate q to the range in REQ-027/REQ-028.
REQ-018: out_data SHALL be computed from the captured copy only, either combinationally or registered, with no added latency beyond REQ-014.
REQ-019: done SHALL be high only in FIN; busy SHALL be 0 in IDLE and FIN and 1 in STREAM.
REQ-020: start while busy=1 SHALL be ignored, with no recapture and no index change.
REQ-021: start in FIN SHALL be accepted; done still pulses in that cycle, and beat 0 of the new stream appears in the next cycle.
REQ-022: out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-023: While rst=1, the block SHALL set state=IDLE, busy=0, out_valid=0, done=0, out_idx=0 and out_data=0, and SHALL clear the captured registers to 0.
REQ-024: rst SHALL take priority over start and over transfers.
REQ-025: A reset mid-stream SHALL abandon the remaining beats, and done SHALL NOT pulse.
REQ-026: The first start SHALL be honoured in the cycle after rst deasserts.

Configuration
REQ-027: With macro ACT_DRAIN_RELU_EN defined, q SHALL be clamped to [0, 127] (ReLU plus saturation).
REQ-028: Without ACT_DRAIN_RELU_EN, q SHALL be clamped to [-128, 127] (signed saturation only); all timing SHALL be identical in both builds.

Verification
REQ-029: Scenario: acc[0]=256, acc[1]=-256, acc[2]=40000, acc[3]=-300, others 0, out_ready=1.
- RELU build -> 1, 0, 127, 0.
- Non-RELU build -> 1, -1, 127, -2.
REQ-030: Scenario: start with out_ready=1 continuously -> out_valid high for exactly 32 consecutive cycles, idx 0..31, then done for 1 cycle and busy low.
REQ-031: Scenario: out_ready toggled 1,0,0,1 repeatedly -> the beat is held stable across the low cycles, 32 transfers total, no beat duplicated or skipped.
REQ-032: Scenario: acc_in_packed changed and start pulsed at beat 10 -> the stream continues with the original captured values and no restart.
REQ-033: Scenario: rst asserted for 1 cycle at beat 15 -> all outputs 0 and no done; the next start streams from idx 0.
REQ-034: Scenario: start asserted in the done cycle -> done=1 that cycle, and out_idx=0 with out_valid=1 in the next cycle.
